// File: rtl/stg_if_if.sv
// Fetch-to-decode bus: address-stage inputs, decode-side controls and the presented pair.
// The slave view belongs to the fetch stage; the master view belongs to whoever drives it.
interface stg_if_if #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 24
);
  logic [ADDR_W-1:0]  iw_pc;
  logic               iw_ia_valid;
  logic [INSTR_W-1:0] iw_mem_data;
  logic               ow_ready;
  logic               iw_stall;
  logic               iw_flush;
  logic [ADDR_W-1:0]  ow_pc;
  logic [INSTR_W-1:0] ow_instr;
  logic               ow_if_valid;
  logic [15:0]        ow_fetch_cnt;

  modport slave (
    input  iw_pc, iw_ia_valid, iw_mem_data, iw_stall, iw_flush,
    output ow_ready, ow_pc, ow_instr, ow_if_valid, ow_fetch_cnt
  );

  modport master (
    output iw_pc, iw_ia_valid, iw_mem_data, iw_stall, iw_flush,
    input  ow_ready, ow_pc, ow_instr, ow_if_valid, ow_fetch_cnt
  );
endinterface

// File: rtl/stg_if.sv
// Instruction-fetch stage: captures {PC, instruction} pairs into a two-entry skid buffer for decode.
// Optional accepted-pair counter is built only when IF_FETCH_CNT_EN is defined.
module stg_if #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 24
) (
  input logic   iw_clk,
  input logic   iw_rst,
  stg_if_if.slave bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_valid;
  logic               r_ready;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_skidPc;
  logic [INSTR_W-1:0] r_skidInstr;
  logic               w_acc;

  // Ready is a registered copy of (state != SKID), so stall never reaches it combinationally.
  assign w_acc = bus.iw_ia_valid & r_ready & ~bus.iw_flush;

  always_ff @(posedge iw_clk) begin
    if (iw_rst || bus.iw_flush) begin
      r_state     <= EMPTY;
      r_valid     <= 1'b0;
      r_ready     <= 1'b1;
      r_pc        <= '0;
      r_instr     <= '0;
      r_skidPc    <= '0;
      r_skidInstr <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_pc    <= bus.iw_pc;
            r_instr <= bus.iw_mem_data;
            r_valid <= 1'b1;
            r_state <= FULL;
          end
        end
        FULL: begin
          if (w_acc && !bus.iw_stall) begin
            r_pc    <= bus.iw_pc;
            r_instr <= bus.iw_mem_data;
          end else if (w_acc && bus.iw_stall) begin
            r_skidPc    <= bus.iw_pc;
            r_skidInstr <= bus.iw_mem_data;
            r_ready     <= 1'b0;
            r_state     <= SKID;
          end else if (!bus.iw_stall) begin
            r_valid <= 1'b0;
            r_state <= EMPTY;
          end
        end
        SKID: begin
          if (!bus.iw_stall) begin
            r_pc    <= r_skidPc;
            r_instr <= r_skidInstr;
            r_ready <= 1'b1;
            r_state <= FULL;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ow_ready    = r_ready;
  assign bus.ow_if_valid = r_valid;
  assign bus.ow_pc       = r_pc;
  assign bus.ow_instr    = r_instr;

`ifdef IF_FETCH_CNT_EN
  logic [15:0] r_fetchCnt;

  // Only reset clears the count; flush leaves it alone and wraps naturally at 16 bits.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_fetchCnt <= 16'd0;
    end else if (w_acc) begin
      r_fetchCnt <= r_fetchCnt + 16'd1;
    end
  end

  assign bus.ow_fetch_cnt = r_fetchCnt;
`else
  assign bus.ow_fetch_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_stg_if.sv
// Self-checking bench for stg_if: directed scenarios plus random traffic against a queue model.
// Counter expectations follow IF_FETCH_CNT_EN.
module tb_stg_if;

  logic clk;
  logic rst;

  stg_if_if #(.ADDR_W(24), .INSTR_W(24)) bus ();

  stg_if #(.ADDR_W(24), .INSTR_W(24)) dut (
    .iw_clk(clk),
    .iw_rst(rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] pc;
    logic [23:0] instr;
  } pair_t;

  pair_t       mq[$];
  logic [15:0] mCnt;
  bit          mZero;
  int          total;
  int          bad;

  function automatic logic [15:0] expCnt();
`ifdef IF_FETCH_CNT_EN
    return mCnt;
`else
    return 16'd0;
`endif
  endfunction

  // Drive one cycle of inputs, advance past the edge, update the model, settle at the falling edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [23:0] pc,
                               input logic [23:0] ins, input bit s, input bit f);
    bit    rdy;
    bit    acc;
    pair_t p;
    rst             = r;
    bus.iw_ia_valid = v;
    bus.iw_pc       = pc;
    bus.iw_mem_data = ins;
    bus.iw_stall    = s;
    bus.iw_flush    = f;
    @(posedge clk);
    rdy = (mq.size() < 2);
    acc = v && rdy && !f;
    if (r) begin
      mq.delete();
      mCnt  = 16'd0;
      mZero = 1'b1;
    end else if (f) begin
      mq.delete();
      mZero = 1'b1;
    end else begin
      if (mq.size() > 0 && !s) void'(mq.pop_front());
      if (acc) begin
        p.pc    = pc;
        p.instr = ins;
        mq.push_back(p);
        mZero = 1'b0;
        mCnt  = mCnt + 16'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    applyStimulus(1, 0, 24'h0, 24'h0, 0, 0);
    total++; if (bus.ow_if_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", bus.ow_if_valid); end
    total++; if (bus.ow_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%b want=1", bus.ow_ready); end
    total++; if (bus.ow_pc !== 24'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h want=0", bus.ow_pc); end
    total++; if (bus.ow_instr !== 24'h0) begin bad++; $display("[TB] FAIL reset_instr got=%h want=0", bus.ow_instr); end
    total++; if (bus.ow_fetch_cnt !== 16'h0) begin bad++; $display("[TB] FAIL reset_cnt got=%h want=0", bus.ow_fetch_cnt); end
  endtask

  task automatic test_streaming();
    int nValid = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 24'h10 + 24'(i), 24'hA00000 + 24'(i), 0, 0);
      if (bus.ow_if_valid === 1'b1) nValid++;
      total++; if (bus.ow_pc !== 24'h10 + 24'(i)) begin bad++; $display("[TB] FAIL stream_pc%0d got=%h want=%h", i, bus.ow_pc, 24'h10 + 24'(i)); end
      total++; if (bus.ow_instr !== 24'hA00000 + 24'(i)) begin bad++; $display("[TB] FAIL stream_instr%0d got=%h want=%h", i, bus.ow_instr, 24'hA00000 + 24'(i)); end
      total++; if (bus.ow_ready !== 1'b1) begin bad++; $display("[TB] FAIL stream_ready%0d got=%b want=1", i, bus.ow_ready); end
    end
    applyStimulus(0, 0, 24'h0, 24'h0, 0, 0);
    if (bus.ow_if_valid === 1'b1) nValid++;
    total++; if (nValid != 4) begin bad++; $display("[TB] FAIL stream_valid_cycles got=%0d want=4", nValid); end
  endtask

  task automatic test_skid();
    bit saw30 = 1'b0;
    applyStimulus(0, 0, 24'h0, 24'h0, 0, 0);
    applyStimulus(0, 1, 24'h20, 24'hB00020, 0, 0);
    total++; if (bus.ow_pc !== 24'h20 || bus.ow_if_valid !== 1'b1) begin bad++; $display("[TB] FAIL skid_first got=%h/%b want=20/1", bus.ow_pc, bus.ow_if_valid); end
    applyStimulus(0, 1, 24'h21, 24'hB00021, 1, 0);
    total++; if (bus.ow_ready !== 1'b0) begin bad++; $display("[TB] FAIL skid_ready_low got=%b want=0", bus.ow_ready); end
    total++; if (bus.ow_pc !== 24'h20) begin bad++; $display("[TB] FAIL skid_hold_pc got=%h want=20", bus.ow_pc); end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 24'h30, 24'hB00030, 1, 0);
      if (bus.ow_if_valid === 1'b1 && bus.ow_pc === 24'h30) saw30 = 1'b1;
      total++; if (bus.ow_pc !== 24'h20 || bus.ow_instr !== 24'hB00020) begin bad++; $display("[TB] FAIL skid_stall_hold%0d got=%h/%h want=20/b00020", i, bus.ow_pc, bus.ow_instr); end
      total++; if (bus.ow_ready !== 1'b0) begin bad++; $display("[TB] FAIL skid_stall_ready%0d got=%b want=0", i, bus.ow_ready); end
    end
    bus.iw_ia_valid = 1'b0;
    bus.iw_stall    = 1'b0;
    #1;
    total++; if (bus.ow_ready !== 1'b0) begin bad++; $display("[TB] FAIL skid_release_ready got=%b want=0", bus.ow_ready); end
    applyStimulus(0, 0, 24'h0, 24'h0, 0, 0);
    if (bus.ow_if_valid === 1'b1 && bus.ow_pc === 24'h30) saw30 = 1'b1;
    total++; if (bus.ow_pc !== 24'h21 || bus.ow_instr !== 24'hB00021) begin bad++; $display("[TB] FAIL skid_release_pair got=%h/%h want=21/b00021", bus.ow_pc, bus.ow_instr); end
    total++; if (bus.ow_ready !== 1'b1) begin bad++; $display("[TB] FAIL skid_ready_back got=%b want=1", bus.ow_ready); end
    applyStimulus(0, 0, 24'h0, 24'h0, 0, 0);
    if (bus.ow_if_valid === 1'b1 && bus.ow_pc === 24'h30) saw30 = 1'b1;
    total++; if (bus.ow_if_valid !== 1'b0) begin bad++; $display("[TB] FAIL skid_drain got=%b want=0", bus.ow_if_valid); end
    total++; if (saw30) begin bad++; $display("[TB] FAIL ignore_full got=seen want=never pc=30"); end
  endtask

  task automatic test_flush_skid();
    logic [15:0] cntBefore;
    applyStimulus(0, 1, 24'h38, 24'hC00038, 0, 0);
    applyStimulus(0, 1, 24'h39, 24'hC00039, 1, 0);
    total++; if (bus.ow_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_pre_ready got=%b want=0", bus.ow_ready); end
    cntBefore = bus.ow_fetch_cnt;
    applyStimulus(0, 1, 24'h40, 24'hC00040, 1, 1);
    total++; if (bus.ow_if_valid !== 1'b0 || bus.ow_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_state got=v%b/r%b want=v0/r1", bus.ow_if_valid, bus.ow_ready); end
    total++; if (bus.ow_pc !== 24'h0 || bus.ow_instr !== 24'h0) begin bad++; $display("[TB] FAIL flush_zero got=%h/%h want=0/0", bus.ow_pc, bus.ow_instr); end
    total++; if (bus.ow_fetch_cnt !== cntBefore || bus.ow_fetch_cnt !== expCnt()) begin bad++; $display("[TB] FAIL flush_cnt got=%h want=%h", bus.ow_fetch_cnt, expCnt()); end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 24'h0, 24'h0, 0, 0);
      total++; if (bus.ow_if_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_drop%0d got=%b/%h want=0", i, bus.ow_if_valid, bus.ow_pc); end
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(0, 1, 24'h50, 24'hD00050, 0, 0);
    applyStimulus(0, 1, 24'h51, 24'hD00051, 1, 0);
    applyStimulus(1, 1, 24'h52, 24'hD00052, 1, 1);
    total++; if (bus.ow_if_valid !== 1'b0 || bus.ow_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_state got=v%b/r%b want=v0/r1", bus.ow_if_valid, bus.ow_ready); end
    total++; if (bus.ow_pc !== 24'h0 || bus.ow_instr !== 24'h0) begin bad++; $display("[TB] FAIL rstmid_data got=%h/%h want=0/0", bus.ow_pc, bus.ow_instr); end
    total++; if (bus.ow_fetch_cnt !== 16'h0) begin bad++; $display("[TB] FAIL rstmid_cnt got=%h want=0", bus.ow_fetch_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), 24'($urandom),
                    24'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
      total++; if (bus.ow_if_valid !== (mq.size() != 0)) begin bad++; $display("[TB] FAIL rand_valid@%0d got=%b want=%b", i, bus.ow_if_valid, mq.size() != 0); end
      total++; if (bus.ow_ready !== (mq.size() != 2)) begin bad++; $display("[TB] FAIL rand_ready@%0d got=%b want=%b", i, bus.ow_ready, mq.size() != 2); end
      if (mq.size() != 0) begin
        total++; if (bus.ow_pc !== mq[0].pc || bus.ow_instr !== mq[0].instr) begin bad++; $display("[TB] FAIL rand_pair@%0d got=%h/%h want=%h/%h", i, bus.ow_pc, bus.ow_instr, mq[0].pc, mq[0].instr); end
      end else if (mZero) begin
        total++; if (bus.ow_pc !== 24'h0 || bus.ow_instr !== 24'h0) begin bad++; $display("[TB] FAIL rand_zero@%0d got=%h/%h want=0/0", i, bus.ow_pc, bus.ow_instr); end
      end
      total++; if (bus.ow_fetch_cnt !== expCnt()) begin bad++; $display("[TB] FAIL rand_cnt@%0d got=%h want=%h", i, bus.ow_fetch_cnt, expCnt()); end
    end
  endtask

  task automatic test_counter();
    int nAcc;
`ifdef IF_FETCH_CNT_EN
    nAcc = 65537;
`else
    nAcc = 40;
`endif
    applyStimulus(1, 0, 24'h0, 24'h0, 0, 0);
    for (int i = 0; i < nAcc; i++) applyStimulus(0, 1, 24'(i), 24'(i), 0, 0);
    total++; if (bus.ow_fetch_cnt !== expCnt()) begin bad++; $display("[TB] FAIL cnt_model got=%h want=%h", bus.ow_fetch_cnt, expCnt()); end
`ifdef IF_FETCH_CNT_EN
    total++; if (bus.ow_fetch_cnt !== 16'h0001) begin bad++; $display("[TB] FAIL cnt_wrap got=%h want=0001", bus.ow_fetch_cnt); end
`else
    total++; if (bus.ow_fetch_cnt !== 16'h0000) begin bad++; $display("[TB] FAIL cnt_absent got=%h want=0000", bus.ow_fetch_cnt); end
`endif
    applyStimulus(0, 1, 24'h60, 24'hE00060, 0, 1);
    total++; if (bus.ow_fetch_cnt !== expCnt()) begin bad++; $display("[TB] FAIL cnt_flush got=%h want=%h", bus.ow_fetch_cnt, expCnt()); end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    mCnt            = 16'd0;
    mZero           = 1'b1;
    rst             = 1'b0;
    bus.iw_ia_valid = 1'b0;
    bus.iw_pc       = '0;
    bus.iw_mem_data = '0;
    bus.iw_stall    = 1'b0;
    bus.iw_flush    = 1'b0;
    @(negedge clk);
    test_reset();
    test_streaming();
    test_skid();
    test_flush_skid();
    test_reset_mid();
    test_random();
    test_counter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stg_if.md
# stg_if

Instruction-fetch stage that terminates the fetch path opened by the instruction-address stage. The address stage drives the instruction-memory address and registers the PC and a valid bit. The synchronous memory returns the instruction word one cycle later, aligned with that registered PC/valid. This block captures each {PC, instruction} pair into a two-entry skid buffer and presents it to decode. It also absorbs decode stalls without losing a word already in flight, and discards everything on flush.

## Interface
Parameters:
- ADDR_W, default 24: PC width; matches `SIZE_ADDR.
- INSTR_W, default 24: instruction word width.

Ports:
- iw_clk, input, 1: sole clock; all state updates on its rising edge.
- iw_rst, input, 1: reset, synchronous, active-high.
- iw_pc, input, ADDR_W: registered PC from the address stage.
- iw_ia_valid, input, 1: iw_pc/iw_mem_data pair is valid this cycle.
- iw_mem_data, input, INSTR_W: instruction-memory read data for iw_pc.
- ow_ready, output, 1: buffer can accept a pair this cycle; upstream holds/replays its PC while low.
- iw_stall, input, 1: decode cannot consume the output this cycle.
- iw_flush, input, 1: discard all buffered and incoming pairs.
- ow_pc, output, ADDR_W: PC of the presented instruction.
- ow_instr, output, INSTR_W: presented instruction word.
- ow_if_valid, output, 1: ow_pc/ow_instr valid.
- ow_fetch_cnt, output, 16: count of accepted pairs (see Configuration).

## Operation
- Storage: main register (drives outputs) plus one skid register; all outputs come directly from flops.
- State machine, 2-bit encoded:
  - EMPTY: nothing held.
  - FULL: main register valid.
  - SKID: main and skid both valid.
- Accept condition: acc = iw_ia_valid & ow_ready & ~iw_flush.
- ow_ready = (state != SKID). It is a function of state only; there is no combinational path from iw_stall.
- Transitions, when neither reset nor flush is asserted:
  - EMPTY: acc → load main, go to FULL; otherwise stay EMPTY.
  - FULL, acc & ~stall → load main with the new pair, stay FULL.
  - FULL, acc & stall → load skid, go to SKID; main is unchanged.
  - FULL, ~acc & ~stall → go to EMPTY.
  - FULL, ~acc & stall → hold.
  - SKID, ~stall → copy skid to main, go to FULL.
  - SKID, stall → hold.
- Input presented while ow_ready=0 is ignored, not stored; upstream is responsible for replaying it.
- Flush: go to EMPTY and drop both entries and any same-cycle input. Data registers are zeroed.
- Priority: reset > flush > normal operation.
- ow_if_valid = (state != EMPTY).
- While iw_stall=1 and ow_if_valid=1, ow_pc and ow_instr are held stable.

## Timing
- Latency: a pair accepted in cycle N appears on the outputs in cycle N+1.
- Throughput: one pair per cycle while iw_stall=0.
- Reset values, at the first edge with iw_rst=1: state EMPTY, ow_if_valid=0, ow_pc=0, ow_instr=0, ow_ready=1, ow_fetch_cnt=0, skid register=0.
- Reset asserted mid-operation overrides any stall or flush in the same cycle.
- Flush during SKID clears both entries; ow_ready returns to 1 in the next cycle.
- Flush and iw_ia_valid asserted together: the input is dropped and the counter does not increment.
- A stall de-asserting while in SKID releases the skid entry the next cycle. ow_ready stays 0 during that release cycle and is 1 in the cycle after.

## Configuration
- IF_FETCH_CNT_EN:
  - Defined: ow_fetch_cnt is a 16-bit register that increments on every acc.
  - It wraps 0xFFFF → 0x0000, is reset only by iw_rst, and is not cleared by flush.
- Not defined: no counter logic is built and ow_fetch_cnt is tied to 0. The port is always present.

## Test plan
- Streaming: after reset, drive PCs 0x000010..0x000013 with instructions 0xA00000..0xA00003 on consecutive cycles, stall=0 → outputs show the same sequence one cycle later; ow_if_valid is high for 4 cycles.
- Skid: while outputting PC 0x20, raise stall for 3 cycles as PC 0x21 arrives → PC 0x21 goes to skid and ow_ready=0; PC 0x20 is held; after stall falls, PC 0x21 appears the next cycle and ow_ready returns to 1 one cycle later.
- Ignore while full: assert iw_ia_valid with PC 0x30 while in SKID → PC 0x30 never appears on the outputs.
- Flush in SKID: flush with PC 0x40 on the input → next cycle ow_if_valid=0, ow_pc=0, ow_ready=1; PC 0x40 is never output.
- Reset mid-stream: assert iw_rst during a stall with a valid output → all outputs match the reset values at the next edge.
- Counter, with IF_FETCH_CNT_EN: preload via 65537 accepts → ow_fetch_cnt=1, showing wrap; flushed inputs are not counted; with the macro undefined, ow_fetch_cnt stays 0.
